// File: rtl/obstacle_spawner.sv
// Obstacle spawner: chooses, places and scrolls one obstacle at a time for the pixel judge,
// freezes on a crash and reports each obstacle that scrolls off the left edge.
module obstacle_spawner #(
  parameter logic [9:0]  SCREEN_W       = 10'd640,
  parameter logic [9:0]  SPAWN_X        = 10'd639,
  parameter logic [9:0]  Y_SMALL        = 10'd330,
  parameter logic [9:0]  Y_BIG          = 10'd300,
  parameter logic [9:0]  Y_BIRD         = 10'd180,
  parameter logic [6:0]  MIN_GAP        = 7'd30,
  parameter logic [3:0]  ANIM_FRAMES    = 4'd8,
  parameter logic [3:0]  BIRD_MIN_SPEED = 4'd4,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       frame_tick,
  input  logic       game_run,
  input  logic       crash,
  input  logic [3:0] speed,
  output logic [9:0] obstacle_x,
  output logic [9:0] obstacle_y,
  output logic [3:0] obstacle_sel,
  output logic       obstacle_valid,
  output logic       animate_clk,
  output logic       pass_pulse
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_MOVE = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic [3:0]  sel_q, sel_d;
  logic        valid_q, valid_d;
  logic        anim_clk_q, anim_clk_d;
  logic [3:0]  anim_cnt_q, anim_cnt_d;
  logic        pass_q, pass_d;
  logic [6:0]  gap_q, gap_d;
  logic [15:0] lfsr_q;
  logic [9:0]  step_s;
  logic [3:0]  spawn_sel_s;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Birds are only fair once the scroll is fast enough; below that they become small cacti.
  function automatic logic [3:0] pick_sel(input logic [2:0] r, input logic [3:0] spd);
    logic [3:0] s;
    case (r)
      3'd2:       s = 4'b0101;
      3'd3:       s = 4'b0110;
      3'd4:       s = 4'b0111;
      3'd6, 3'd7: s = (spd < BIRD_MIN_SPEED) ? 4'b0100 : 4'b1000;
      default:    s = 4'b0100;
    endcase
    return s;
  endfunction

  function automatic logic [9:0] pick_y(input logic [3:0] sel);
    logic [9:0] y;
    case (sel)
      4'b1000:          y = Y_BIRD;
      4'b0101, 4'b0111: y = Y_BIG;
      default:          y = Y_SMALL;
    endcase
    return y;
  endfunction

  assign step_s      = (speed == 4'd0) ? 10'd1 : {6'd0, speed};
  assign spawn_sel_s = pick_sel(lfsr_q[2:0], speed);

  // Next-state and next-output logic; game_run low overrides everything, then crash, then frame_tick.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    sel_d      = sel_q;
    valid_d    = valid_q;
    anim_clk_d = anim_clk_q;
    anim_cnt_d = anim_cnt_q;
    pass_d     = 1'b0;
    gap_d      = gap_q;
    if (!game_run) begin
      state_d    = S_IDLE;
      x_d        = SCREEN_W;
      y_d        = 10'd0;
      sel_d      = 4'd0;
      valid_d    = 1'b0;
      anim_clk_d = 1'b0;
      anim_cnt_d = 4'd0;
      gap_d      = MIN_GAP;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_WAIT;
          gap_d   = MIN_GAP;
        end
        S_WAIT: begin
          if (crash) begin
            state_d = S_HALT;
          end else if (frame_tick) begin
            if (gap_q == 7'd0) begin
              state_d = S_MOVE;
              x_d     = SPAWN_X;
              sel_d   = spawn_sel_s;
              y_d     = pick_y(spawn_sel_s);
              valid_d = 1'b1;
            end else begin
              gap_d = gap_q - 7'd1;
            end
          end else begin
            state_d = S_WAIT;
          end
        end
        S_MOVE: begin
          if (crash) begin
            state_d = S_HALT;
          end else if (frame_tick) begin
            if (anim_cnt_q == ANIM_FRAMES - 4'd1) begin
              anim_clk_d = ~anim_clk_q;
              anim_cnt_d = 4'd0;
            end else begin
              anim_cnt_d = anim_cnt_q + 4'd1;
            end
            // Despawn instead of letting X reach zero or wrap.
            if (x_q > step_s) begin
              x_d = x_q - step_s;
            end else begin
              state_d = S_WAIT;
              x_d     = SCREEN_W;
              sel_d   = 4'd0;
              valid_d = 1'b0;
              pass_d  = 1'b1;
              gap_d   = MIN_GAP + {2'b00, lfsr_q[7:3]};
            end
          end else begin
            state_d = S_MOVE;
          end
        end
        S_HALT: begin
          state_d = S_HALT;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State, output and LFSR registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      x_q        <= SCREEN_W;
      y_q        <= 10'd0;
      sel_q      <= 4'd0;
      valid_q    <= 1'b0;
      anim_clk_q <= 1'b0;
      anim_cnt_q <= 4'd0;
      pass_q     <= 1'b0;
      gap_q      <= MIN_GAP;
      lfsr_q     <= LFSR_SEED;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      sel_q      <= sel_d;
      valid_q    <= valid_d;
      anim_clk_q <= anim_clk_d;
      anim_cnt_q <= anim_cnt_d;
      pass_q     <= pass_d;
      gap_q      <= gap_d;
      lfsr_q     <= lfsr_step(lfsr_q);
    end
  end

  assign obstacle_x     = x_q;
  assign obstacle_y     = y_q;
  assign obstacle_sel   = sel_q;
  assign obstacle_valid = valid_q;
  assign animate_clk    = anim_clk_q;
  assign pass_pulse     = pass_q;

endmodule
